// File: rtl/fetch_queue.sv
// fetch_queue
//    Decoupling buffer between the fetch stage and decode. Holds up to DEPTH
//    (pc, instr) pairs in arrival order and presents the oldest one to decode
//    combinationally (show-ahead). Fetch stalls only when the queue is full.
//    A flush (branch/jump redirect) discards every entry at the next edge.
//
// Ports
//    clk      in   clock, all state updates on the rising edge
//    reset    in   synchronous active-high, empties the queue
//    f_valid  in   fetch presents a valid pair
//    f_pc     in   PC of the presented instruction
//    f_instr  in   instruction word read at f_pc
//    f_ready  out  queue can accept; drives the PC register enable
//    flush    in   redirect, discards all entries
//    d_valid  out  head entry valid
//    d_pc     out  PC of the head entry (RESET_PC when empty)
//    d_instr  out  instruction of the head entry (0 / nop when empty)
//    d_ready  in   decode consumes the head this cycle
//    count    out  current occupancy, 0..DEPTH

module fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter int          PTR_W    = 2,
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             f_valid,
   input  logic [31:0]      f_pc,
   input  logic [31:0]      f_instr,
   output logic             f_ready,
   input  logic             flush,
   output logic             d_valid,
   output logic [31:0]      d_pc,
   output logic [31:0]      d_instr,
   input  logic             d_ready,
   output logic [PTR_W:0]   count
);

   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [63:0]      mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   cnt_q,    cnt_d;
   logic             push, pop;
   logic [63:0]      head;

   // Handshakes depend on registered occupancy only, so a full queue refuses
   // a push even when decode pops in the same cycle.
   assign f_ready = (cnt_q != FULL_CNT);
   assign d_valid = (cnt_q != '0);
   assign push    = f_valid & f_ready & ~flush;
   assign pop     = d_valid & d_ready & ~flush;

   assign head    = mem_q[rd_ptr_q];
   assign d_pc    = d_valid ? head[63:32] : RESET_PC;
   assign d_instr = d_valid ? head[31:0]  : 32'h0000_0000;
   assign count   = cnt_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         if (push && !pop)      cnt_d = cnt_q + (PTR_W+1)'(1);
         else if (pop && !push) cnt_d = cnt_q - (PTR_W+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage has no reset; entries are only observed while counted valid.
   always_ff @(posedge clk) begin
      if (push && !reset) mem_q[wr_ptr_q] <= {f_pc, f_instr};
   end

endmodule
